uart_cmd_wrapper: RTL and testbench

Copter-side end of the host command link. Receives 3-byte command packets (opcode, data high, data low) over a UART RX line and presents them as a parallel `cmd`/`data` pair with a ready flag to the command-processing logic. It also serialises a single response byte (normally ack 0xA5) back to the host on TX. It sits between the `RX`/`TX` pins of `QuadCopter` and the flight command FSM.

---
 rtl/qc_cmd_pkg.sv | 15 +
 rtl/uart_trx.sv | 105 ++++++++++
 rtl/uart_cmd_wrapper.sv | 95 +++++++++
 tb/tb_uart_cmd_wrapper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qc_cmd_pkg.sv
// Shared types and opcode constants for the host command link.
package qc_cmd_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} pkt_state_t;

  localparam logic [7:0] STPTCH  = 8'h02;
  localparam logic [7:0] STRLL   = 8'h03;
  localparam logic [7:0] STYW    = 8'h04;
  localparam logic [7:0] STTHRST = 8'h05;
  localparam logic [7:0] CAL     = 8'h06;
  localparam logic [7:0] EMER    = 8'h07;
  localparam logic [7:0] MTSOFF  = 8'h08;
  localparam logic [7:0] ACK     = 8'hA5;

endpackage

// File: rtl/uart_trx.sv
// 8N1 UART: independent RX (mid-bit sampling, framing check) and TX engines.
module uart_trx
  import qc_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  logic          r_rx_s1, r_rx_s2, r_rx_s3;
  logic          r_rx_busy, r_rx_rdy;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;

  // Bit 0 is the start bit, 1..8 data, 9 stop; engine frees itself mid-stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_rdy   <= 1'b0;
      r_rx_baud  <= '0;
      r_rx_bit   <= 4'd0;
      r_rx_shift <= 8'h00;
    end else begin
      r_rx_s1  <= rx;
      r_rx_s2  <= r_rx_s1;
      r_rx_s3  <= r_rx_s2;
      r_rx_rdy <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_s3 && !r_rx_s2) begin
          r_rx_busy <= 1'b1;
          r_rx_baud <= '0;
          r_rx_bit  <= 4'd0;
        end
      end else begin
        r_rx_baud <= (r_rx_baud == BAUD_LAST) ? '0 : r_rx_baud + 1'b1;
        if (r_rx_baud == BAUD_LAST) r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_baud == BAUD_HALF) begin
          if (r_rx_bit == 4'd9) begin
            r_rx_busy <= 1'b0;
            r_rx_rdy  <= r_rx_s2;
          end else if (r_rx_bit != 4'd0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          end
        end
      end
    end
  end

  assign rx_rdy  = r_rx_rdy;
  assign rx_data = r_rx_shift;

  logic          r_tx_busy, r_tx_done;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic [9:0]    r_tx_shift;

  // Line is driven straight from the shifter LSB; ones fill in behind the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_baud  <= '0;
      r_tx_bit   <= 4'd0;
      r_tx_shift <= '1;
    end else if (!r_tx_busy) begin
      if (trmt) begin
        r_tx_shift <= {1'b1, tx_data, 1'b0};
        r_tx_busy  <= 1'b1;
        r_tx_done  <= 1'b0;
        r_tx_baud  <= '0;
        r_tx_bit   <= 4'd0;
      end
    end else if (r_tx_baud == BAUD_LAST) begin
      r_tx_baud  <= '0;
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
        r_tx_done <= 1'b1;
      end else begin
        r_tx_bit <= r_tx_bit + 4'd1;
      end
    end else begin
      r_tx_baud <= r_tx_baud + 1'b1;
    end
  end

  assign tx      = r_tx_shift[0];
  assign tx_done = r_tx_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host command link: assembles 3-byte packets into cmd/data, sends one response byte.
// Optional PKT_TIMEOUT_EN drops partial packets after TIMEOUT_CYC idle clocks.
module uart_cmd_wrapper
  import qc_cmd_pkg::*;
#(
  parameter int          BAUD_DIV    = 2604,
  parameter logic [21:0] TIMEOUT_CYC = 22'd2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);
  logic       w_rx_rdy;
  logic [7:0] w_rx_data;

  uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (RX),
    .rx_rdy (w_rx_rdy),
    .rx_data(w_rx_data),
    .trmt   (send_resp),
    .tx_data(resp),
    .tx     (TX),
    .tx_done(resp_sent)
  );

  pkt_state_t  r_state;
  logic [7:0]  r_cmd;
  logic [15:0] r_data;
  logic        r_cmd_rdy;
`ifdef PKT_TIMEOUT_EN
  logic [21:0] r_gap;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

  // The set in LOW is written after the clear so a coincident clear loses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cmd     <= 8'h00;
      r_data    <= 16'h0000;
      r_cmd_rdy <= 1'b0;
`ifdef PKT_TIMEOUT_EN
      r_gap     <= 22'd0;
`endif
    end else begin
      if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      if (w_rx_rdy) begin
        case (r_state)
          IDLE: begin
            r_cmd     <= w_rx_data;
            r_cmd_rdy <= 1'b0;
            r_state   <= HIGH;
          end
          HIGH: begin
            r_data[15:8] <= w_rx_data;
            r_state      <= LOW;
          end
          LOW: begin
            r_data[7:0] <= w_rx_data;
            r_cmd_rdy   <= 1'b1;
            r_state     <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
`ifdef PKT_TIMEOUT_EN
      if (r_state == IDLE || w_rx_rdy) begin
        r_gap <= 22'd0;
      end else if (r_gap == TIMEOUT_CYC - 22'd1) begin
        r_gap   <= 22'd0;
        r_state <= IDLE;
      end else begin
        r_gap <= r_gap + 22'd1;
      end
`endif
    end
  end

  assign cmd     = r_cmd;
  assign data    = r_data;
  assign cmd_rdy = r_cmd_rdy;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Directed + randomized bench for uart_cmd_wrapper against a byte-queue packet model.
module tb_uart_cmd_wrapper;
  import qc_cmd_pkg::*;

  localparam int          B   = 16;
  localparam logic [21:0] TMO = 22'd600;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic [7:0]  resp = 8'h00;
  logic        send_resp = 1'b0;
  logic        resp_sent;

  int n_chk = 0;
  int n_fail = 0;
  bit tx_done_once = 1'b0;

  // Reference model state: bytes of the packet in progress plus visible outputs.
  logic [7:0]  q[$];
  logic [7:0]  m_cmd = 8'h00;
  logic [15:0] m_data = 16'h0000;
  logic        m_rdy = 1'b0;

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT_CYC(TMO)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .cmd        (cmd),
    .data       (data),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    q.push_back(b);
    if (q.size() == 1) begin
      m_cmd = b;
      m_rdy = 1'b0;
    end else if (q.size() == 2) begin
      m_data[15:8] = b;
    end else begin
      m_data = {q[1], q[2]};
      m_rdy  = 1'b1;
      q.delete();
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cmd = 8'h00; m_data = 16'h0000; m_rdy = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'(m_cmd));
    chk({tag, "_data"}, 32'(data), 32'(m_data));
    chk({tag, "_rdy"}, 32'(cmd_rdy), 32'(m_rdy));
  endtask

  // One 8N1 frame on RX, then two idle bit times.
  task automatic host_byte(input logic [7:0] b, input logic stop, input string tag);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); RX = fr[i];
      repeat (B - 1) @(negedge clk);
    end
    @(negedge clk); RX = 1'b1;
    repeat (2 * B - 1) @(negedge clk);
    if (stop) model_byte(b);
    check_state(tag);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_cmd_rdy = 1'b1;
    @(negedge clk); clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  // Sends r and checks every bit mid-cell; poke fires a second request mid-frame.
  task automatic tx_resp(input logic [7:0] r, input bit poke);
    logic [9:0] fr;
    fr = {1'b1, r, 1'b0};
    @(negedge clk);
    if (tx_done_once) chk("resp_sent_hold", 32'(resp_sent), 32'd1);
    resp = r; send_resp = 1'b1;
    @(negedge clk); send_resp = 1'b0; resp = 8'($urandom);
    chk("tx_fall", 32'(TX), 32'd0);
    chk("resp_sent_clr", 32'(resp_sent), 32'd0);
    repeat (B / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tx_bit%0d", i), 32'(TX), 32'(fr[i]));
      if (i < 9) begin
        if (poke && i == 4) begin
          @(negedge clk); resp = ~r; send_resp = 1'b1;
          @(negedge clk); send_resp = 1'b0;
          repeat (B - 2) @(negedge clk);
        end else begin
          repeat (B) @(negedge clk);
        end
      end
    end
    repeat (B / 2 - 1) @(negedge clk);
    chk("resp_sent_early", 32'(resp_sent), 32'd0);
    @(negedge clk);
    chk("resp_sent_rise", 32'(resp_sent), 32'd1);
    tx_done_once = 1'b1;
  endtask

  initial begin
    logic [7:0] ops[7];
    int t_rise;
    bit seen;
    logic [7:0]  c;
    logic [15:0] d;
    ops = '{STPTCH, STRLL, STYW, STTHRST, CAL, EMER, MTSOFF};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_resp_sent", 32'(resp_sent), 32'd0);
    check_state("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Calibrate packet with latency bound on cmd_rdy
    t_rise = -1;
    fork
      begin
        host_byte(CAL, 1'b1, "cal_b1");
        host_byte(8'h00, 1'b1, "cal_b2");
        host_byte(8'h00, 1'b1, "cal_b3");
      end
      begin
        for (int k = 0; k < 40 * B; k++) begin
          @(negedge clk);
          if (cmd_rdy && t_rise < 0) t_rise = k;
        end
      end
    join
    chk("cal_rdy_seen", 32'(t_rise >= 0), 32'd1);
    chk("cal_latency_min", 32'(t_rise >= 30 * B), 32'd1);
    chk("cal_latency_max", 32'(t_rise <= 36 * B), 32'd1);

    // Thrust packet, clear coincident with third rx_rdy must lose
    host_byte(STTHRST, 1'b1, "thr_b1");
    host_byte(8'h00, 1'b1, "thr_b2");
    seen = 1'b0;
    fork
      host_byte(8'hFF, 1'b1, "thr_b3");
      begin
        for (int k = 0; k < 12 * B && !seen; k++) begin
          @(negedge clk);
          if (u_dut.w_rx_rdy) begin
            seen = 1'b1;
            clr_cmd_rdy = 1'b1;
            @(negedge clk); clr_cmd_rdy = 1'b0;
            chk("clr_vs_set", 32'(cmd_rdy), 32'd1);
          end
        end
      end
    join
    chk("thr_rx_rdy_seen", 32'(seen), 32'd1);
    pulse_clr();
    check_state("thr_clr");
    pulse_clr();
    check_state("thr_clr_idle");

    // Ack response, second request mid-frame ignored
    tx_resp(ACK, 1'b1);

    // Framing error then clean packet
    host_byte(STRLL, 1'b0, "frm_bad");
    host_byte(STRLL, 1'b1, "frm_b1");
    host_byte(8'h12, 1'b1, "frm_b2");
    host_byte(8'h34, 1'b1, "frm_b3");

    // Reset mid-packet
    host_byte(STYW, 1'b1, "rstm_b1");
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    tx_done_once = 1'b0;
    chk("rstm_tx", 32'(TX), 32'd1);
    chk("rstm_resp_sent", 32'(resp_sent), 32'd0);
    check_state("rstm");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    host_byte(STPTCH, 1'b1, "pch_b1");
    host_byte(8'h80, 1'b1, "pch_b2");
    host_byte(8'h01, 1'b1, "pch_b3");

    // Randomized full-duplex traffic
    for (int p = 0; p < 6; p++) begin
      c = ops[$urandom_range(0, 6)];
      d = 16'($urandom);
      fork
        tx_resp(8'($urandom), 1'b0);
        begin
          host_byte(c, 1'b1, "rnd_b1");
          host_byte(d[15:8], 1'b1, "rnd_b2");
          host_byte(d[7:0], 1'b1, "rnd_b3");
        end
      join
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_state("rnd_clr");
      end
    end

`ifdef PKT_TIMEOUT_EN
    pulse_clr();
    host_byte(EMER, 1'b1, "tmo_b1");
    host_byte(8'h11, 1'b1, "tmo_b2");
    repeat (int'(TMO) + 10) @(negedge clk);
    q.delete();
    check_state("tmo_wait");
    host_byte(MTSOFF, 1'b1, "tmo_n1");
    host_byte(8'h00, 1'b1, "tmo_n2");
    host_byte(8'h00, 1'b1, "tmo_n3");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
